// File: rtl/trivial_rotation_ctrl.sv
// rtl/trivial_rotation_ctrl.sv - trivial (1 / -i) rotation sequencer for a radix-2^2 SDF FFT stage
//
// Tracks each sample's position in the FFT frame, multiplies the last quarter
// of every BLOCK-sized group by -i (unless the frame is bypassed), and presents
// the result through a one-entry registered valid/ready output stage.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready = !out_valid | out_ready)
//   in_sop              first sample of a frame, resynchronises the index
//   in_r/in_i           input sample (two's complement)
//   bypass              frame-level rotation disable, taken at index 0
//   out_valid/out_ready output handshake
//   out_r/out_i         rotated sample
//   out_sop/out_eop     first / last sample of frame, aligned with out_r/out_i
//   sop_err             sticky flag: in_sop seen at a nonzero index

module trivial_rotation_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int N_POINTS   = 16,
  parameter int BLOCK      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sop,
  input  logic [DATA_WIDTH-1:0] in_r,
  input  logic [DATA_WIDTH-1:0] in_i,
  input  logic                  bypass,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_r,
  output logic [DATA_WIDTH-1:0] out_i,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  sop_err
);

  localparam int IDX_W = $clog2(N_POINTS);

  // BLOCK is a power of two no larger than N_POINTS, so "mod BLOCK" is a mask.
  localparam logic [IDX_W-1:0] K_MASK   = IDX_W'(BLOCK - 1);
  localparam logic [IDX_W-1:0] K_FLIP   = IDX_W'((3 * BLOCK) / 4);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_POINTS - 1);

  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  byp_q, byp_d;
  logic                  sop_err_q, sop_err_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_r_q, out_r_d;
  logic [DATA_WIDTH-1:0] out_i_q, out_i_d;
  logic                  out_sop_q, out_sop_d;
  logic                  out_eop_q, out_eop_d;

  logic                  in_xfer;
  logic                  out_xfer;
  logic [IDX_W-1:0]      eff_idx;
  logic [IDX_W-1:0]      k;
  logic                  byp_use;
  logic                  flip;
  logic [DATA_WIDTH-1:0] neg_r;
  logic [DATA_WIDTH-1:0] rot_r;
  logic [DATA_WIDTH-1:0] rot_i;

  // The register can take a new sample whenever it is empty or being drained
  // in the same cycle, which keeps one sample per cycle under out_ready = 1.
  assign in_ready = !out_valid_q | out_ready;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid_q & out_ready;

  always_comb begin
    eff_idx = in_sop ? '0 : idx_q;
    // The first sample of a frame uses the live bypass input; the rest of the
    // frame uses the value captured alongside it.
    byp_use = (eff_idx == '0) ? bypass : byp_q;
    k       = eff_idx & K_MASK;
    flip    = (k >= K_FLIP) & !byp_use;
    // Negation wraps at DATA_WIDTH bits: the most negative value maps to itself.
    neg_r   = '0 - in_r;
    rot_r   = flip ? in_i  : in_r;
    rot_i   = flip ? neg_r : in_i;
  end

  always_comb begin
    idx_d       = idx_q;
    byp_d       = byp_q;
    sop_err_d   = sop_err_q;
    out_valid_d = out_valid_q;
    out_r_d     = out_r_q;
    out_i_d     = out_i_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;

    if (in_xfer) begin
      idx_d       = eff_idx + IDX_W'(1);
      if (eff_idx == '0) begin
        byp_d = bypass;
      end
      if (in_sop && (idx_q != '0)) begin
        sop_err_d = 1'b1;
      end
      out_valid_d = 1'b1;
      out_r_d     = rot_r;
      out_i_d     = rot_i;
      out_sop_d   = (eff_idx == '0);
      out_eop_d   = (eff_idx == IDX_LAST);
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      byp_q       <= 1'b0;
      sop_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      byp_q       <= byp_d;
      sop_err_q   <= sop_err_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_i     = out_i_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign sop_err   = sop_err_q;

endmodule
